fifo_showahead: RTL

Synchronous single-clock show-ahead FIFO control stage. It generates write/read pointers, occupancy and flags, and drives the registered-read dual-port RAM that stores the data. It presents the head word on q_o whenever empty_o is low, so downstream logic consumes data with a plain rdreq_i acknowledge.

---
 rtl/fifo_pkg.sv | 7 +
 rtl/ram_memory.sv | 21 ++
 rtl/fifo_showahead.sv | 73 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared default parameters for all FIFO users
package fifo_pkg;
  localparam int FIFO_DWIDTH       = 8;
  localparam int FIFO_AWIDTH       = 4;
  localparam int FIFO_ALMOST_FULL  = 12;
  localparam int FIFO_ALMOST_EMPTY = 2;
endpackage

// File: rtl/ram_memory.sv
// ram_memory: simple dual-port RAM, registered read, old data on read-during-write
module ram_memory
  import fifo_pkg::*;
#(
  parameter int DWIDTH = FIFO_DWIDTH,
  parameter int AWIDTH = FIFO_AWIDTH
) (
  input  logic              clk_i,
  input  logic              wren_i,
  input  logic [AWIDTH-1:0] wraddr_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic [AWIDTH-1:0] rdaddr_i,
  output logic [DWIDTH-1:0] q_o
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  // nonblocking write and read in one block give old data on same-address collisions
  always_ff @(posedge clk_i) begin
    if (wren_i) mem[wraddr_i] <= data_i;
    q_o <= mem[rdaddr_i];
  end
endmodule

// File: rtl/fifo_showahead.sv
// fifo_showahead: show-ahead FIFO control with pointers, occupancy and flags over a registered-read RAM
module fifo_showahead
  import fifo_pkg::*;
#(
  parameter int DWIDTH       = FIFO_DWIDTH,
  parameter int AWIDTH       = FIFO_AWIDTH,
  parameter int ALMOST_FULL  = FIFO_ALMOST_FULL,
  parameter int ALMOST_EMPTY = FIFO_ALMOST_EMPTY
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o
);
  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AF    = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE    = (AWIDTH+1)'(ALMOST_EMPTY);
  logic [AWIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, usedw_q, usedw_d;
  logic empty_q, empty_d, full_q, full_d, af_q, af_d, ae_q, ae_d;
  logic wr_acc, rd_acc;
  // accept requests, advance pointers; empty compares against the pre-edge write pointer so a fresh word waits one edge
  always_comb begin
    wr_acc   = wrreq_i & ~full_q;
    rd_acc   = rdreq_i & ~empty_q;
    wr_ptr_d = wr_ptr_q + {{AWIDTH{1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{AWIDTH{1'b0}}, rd_acc};
    usedw_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = rd_ptr_d == wr_ptr_q;
    full_d   = usedw_d == DEPTH;
    af_d     = usedw_d >= AF;
    ae_d     = usedw_d < AE;
  end
  // state registers with synchronous reset discarding all contents
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end
  ram_memory #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
    .clk_i    (clk_i),
    .wren_i   (wr_acc & ~srst_i),
    .wraddr_i (wr_ptr_q[AWIDTH-1:0]),
    .data_i   (data_i),
    .rdaddr_i (rd_ptr_d[AWIDTH-1:0]),
    .q_o      (q_o)
  );
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign usedw_o        = usedw_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
endmodule
